// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the N-digit up/down counter.
package bcd_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned PRESC_W = 16;

    localparam logic [BCD_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

    // Any nibble above 9 is forced to 9 so count never holds an illegal digit.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the up/down counter.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   step_in      advance this digit on this edge
//   up_down      1 = up, 0 = down
//   load         synchronous load of load_digit (clamped to 9)
//   load_digit   preset nibble
//   clr          synchronous clear, beats load and step
//   digit        registered digit value
//   term         digit is at its terminal value for the current direction
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             step_in,
    input  logic             up_down,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    input  logic             clr,
    output logic [BCD_W-1:0] digit,
    output logic             term
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    assign term  = up_down ? (digit_q == BCD_MAX) : (digit_q == BCD_ZERO);
    assign digit = digit_q;

    // Next digit: clr > load > step > hold; terminal digits roll over.
    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = BCD_ZERO;
        end else if (load) begin
            digit_d = bcd_clamp(load_digit);
        end else if (step_in) begin
            if (up_down) begin
                digit_d = term ? BCD_ZERO : digit_q + 4'd1;
            end else begin
                digit_d = term ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= BCD_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with prescaler, load, clear, wrap/saturate mode.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           count enable, also gates the prescaler
//   up_down      1 = count up, 0 = count down
//   clr          synchronous clear (highest priority)
//   load         synchronous load of load_val (digits clamped to 9)
//   load_val     preset value, digit 0 in [3:0]
//   count        registered count, digit 0 in [3:0]
//   carry        one-cycle pulse on wrap (up) or borrow (down)
//   ovf_sticky   set by any wrap or blocked saturation step, cleared by clr/rst
//   at_zero      combinational count == 0
module bcd_updown_counter_n
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 2,
    parameter int unsigned TICK_DIV   = 1,
    parameter int unsigned SATURATE   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        up_down,
    input  logic                        clr,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
    output logic [BCD_W*NUM_DIGITS-1:0] count,
    output logic                        carry,
    output logic                        ovf_sticky,
    output logic                        at_zero
);

    localparam int unsigned CNT_W = BCD_W * NUM_DIGITS;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic               SAT_MODE   = (SATURATE != 0);

    logic [PRESC_W-1:0]    presc_q;
    logic [PRESC_W-1:0]    presc_d;
    logic                  carry_q;
    logic                  carry_d;
    logic                  ovf_q;
    logic                  ovf_d;
    logic                  tick;
    logic                  all_term;
    logic                  step0;
    logic [NUM_DIGITS-1:0] step;
    logic [NUM_DIGITS-1:0] term;

    assign tick     = en & (presc_q == PRESC_LAST);
    assign all_term = &term;
    // In saturate mode the terminal step is swallowed before reaching the digits.
    assign step0    = tick & ~(SAT_MODE & all_term);

    // Digit chain: digit i steps when every lower digit is terminal.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        if (g == 0) begin : g_lsd
            assign step[g] = step0;
        end else begin : g_upper
            assign step[g] = step0 & (&term[g-1:0]);
        end

        bcd_digit_cell u_cell (
            .clk        (clk),
            .rst        (rst),
            .step_in    (step[g]),
            .up_down    (up_down),
            .load       (load),
            .load_digit (load_val[g*BCD_W +: BCD_W]),
            .clr        (clr),
            .digit      (count[g*BCD_W +: BCD_W]),
            .term       (term[g])
        );
    end

    // Prescaler, carry pulse and sticky overflow next-state.
    always_comb begin
        presc_d = presc_q;
        carry_d = 1'b0;
        ovf_d   = ovf_q;
        if (clr) begin
            presc_d = '0;
            ovf_d   = 1'b0;
        end else if (load) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = tick ? '0 : presc_q + PRESC_W'(1);
            if (tick && all_term) begin
                ovf_d   = 1'b1;
                carry_d = ~SAT_MODE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign carry      = carry_q;
    assign ovf_sticky = ovf_q;
    assign at_zero    = (count == CNT_W'(0));

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Self-checking bench: four counter configurations share stimulus; a decimal
// reference model feeds a scoreboard every cycle, plus a vector table and
// hand-written corner-case sequences with spec-derived constants.
module tb_bcd_updown_counter_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        up_down = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [15:0] lv = '0;

    // a: 2 digits wrap; b: 2 digits saturate; c: 2 digits TICK_DIV=3; d: 4 digits wrap
    logic [7:0]  cnt_a, cnt_b, cnt_c;
    logic [15:0] cnt_d;
    logic        cy_a, cy_b, cy_c, cy_d;
    logic        ov_a, ov_b, ov_c, ov_d;
    logic        z_a, z_b, z_c, z_d;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_updown_counter_n #(.NUM_DIGITS(2), .TICK_DIV(1), .SATURATE(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .clr(clr), .load(load),
        .load_val(lv[7:0]), .count(cnt_a), .carry(cy_a), .ovf_sticky(ov_a), .at_zero(z_a));
    bcd_updown_counter_n #(.NUM_DIGITS(2), .TICK_DIV(1), .SATURATE(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .clr(clr), .load(load),
        .load_val(lv[7:0]), .count(cnt_b), .carry(cy_b), .ovf_sticky(ov_b), .at_zero(z_b));
    bcd_updown_counter_n #(.NUM_DIGITS(2), .TICK_DIV(3), .SATURATE(0)) u_c (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .clr(clr), .load(load),
        .load_val(lv[7:0]), .count(cnt_c), .carry(cy_c), .ovf_sticky(ov_c), .at_zero(z_c));
    bcd_updown_counter_n #(.NUM_DIGITS(4), .TICK_DIV(1), .SATURATE(0)) u_d (
        .clk(clk), .rst(rst), .en(en), .up_down(up_down), .clr(clr), .load(load),
        .load_val(lv), .count(cnt_d), .carry(cy_d), .ovf_sticky(ov_d), .at_zero(z_d));

    // ---------------- reference model (decimal integers) ----------------
    int m_val[4];
    int m_presc[4];
    bit m_carry[4];
    bit m_ovf[4];

    function automatic int cfg_nd(input int k);
        return (k == 3) ? 4 : 2;
    endfunction
    function automatic int cfg_div(input int k);
        return (k == 2) ? 3 : 1;
    endfunction
    function automatic bit cfg_sat(input int k);
        return (k == 1);
    endfunction

    function automatic int max_val(input int nd);
        int p = 1;
        for (int i = 0; i < nd; i++) p = p * 10;
        return p - 1;
    endfunction

    function automatic int clamp_load(input logic [15:0] v, input int nd);
        int r = 0;
        int p = 1;
        int nib;
        for (int i = 0; i < nd; i++) begin
            nib = int'((v >> (4 * i)) & 16'hF);
            if (nib > 9) nib = 9;
            r = r + nib * p;
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < nd; i++) begin
            r = r | (32'(x % 10) << (4 * i));
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_val[k] = 0; m_presc[k] = 0; m_carry[k] = 1'b0; m_ovf[k] = 1'b0;
        end
    endtask

    task automatic model_edge(input int k, input bit c, input bit l, input bit e,
                              input bit ud, input logic [15:0] v);
        int mx = max_val(cfg_nd(k));
        bit tk;
        m_carry[k] = 1'b0;
        if (c) begin
            m_val[k] = 0; m_presc[k] = 0; m_ovf[k] = 1'b0;
        end else if (l) begin
            m_val[k] = clamp_load(v, cfg_nd(k)); m_presc[k] = 0;
        end else if (e) begin
            tk = (m_presc[k] == cfg_div(k) - 1);
            m_presc[k] = tk ? 0 : m_presc[k] + 1;
            if (tk) begin
                if ((ud && m_val[k] == mx) || (!ud && m_val[k] == 0)) begin
                    m_ovf[k] = 1'b1;
                    if (!cfg_sat(k)) begin
                        m_val[k]   = ud ? 0 : mx;
                        m_carry[k] = 1'b1;
                    end
                end else begin
                    m_val[k] = ud ? m_val[k] + 1 : m_val[k] - 1;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          inst;
        logic [31:0] cnt;
        bit          carry;
        bit          ovf;
        bit          zero;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic get_dut(input int k, output logic [31:0] c, output logic cy,
                           output logic ov, output logic z);
        case (k)
            0:       begin c = 32'(cnt_a); cy = cy_a; ov = ov_a; z = z_a; end
            1:       begin c = 32'(cnt_b); cy = cy_b; ov = ov_b; z = z_b; end
            2:       begin c = 32'(cnt_c); cy = cy_c; ov = ov_c; z = z_c; end
            default: begin c = 32'(cnt_d); cy = cy_d; ov = ov_d; z = z_d; end
        endcase
    endtask

    // Drive one edge's inputs, predict all instances, then compare after the edge.
    task automatic cycle(input bit c, input bit l, input bit e, input bit ud,
                         input logic [15:0] v);
        exp_t x;
        logic [31:0] ac;
        logic acy, aov, az;
        clr = c; load = l; en = e; up_down = ud; lv = v;
        for (int k = 0; k < 4; k++) begin
            model_edge(k, c, l, e, ud, v);
            x.inst  = k;
            x.cnt   = to_bcd(m_val[k], cfg_nd(k));
            x.carry = m_carry[k];
            x.ovf   = m_ovf[k];
            x.zero  = (m_val[k] == 0);
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            get_dut(x.inst, ac, acy, aov, az);
            chk($sformatf("sb%0d.count", x.inst), ac, x.cnt);
            chk($sformatf("sb%0d.carry", x.inst), 32'(acy), 32'(x.carry));
            chk($sformatf("sb%0d.ovf", x.inst), 32'(aov), 32'(x.ovf));
            chk($sformatf("sb%0d.at_zero", x.inst), 32'(az), 32'(x.zero));
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".cnt_a"}, 32'(cnt_a), 32'h0);
        chk({tag, ".cnt_b"}, 32'(cnt_b), 32'h0);
        chk({tag, ".cnt_c"}, 32'(cnt_c), 32'h0);
        chk({tag, ".cnt_d"}, 32'(cnt_d), 32'h0);
        chk({tag, ".carry"}, 32'({cy_a, cy_b, cy_c, cy_d}), 32'h0);
        chk({tag, ".ovf"},   32'({ov_a, ov_b, ov_c, ov_d}), 32'h0);
        chk({tag, ".zero"},  32'({z_a, z_b, z_c, z_d}), 32'hF);
    endtask

    // ---------------- vector table for instance a ----------------
    typedef struct {
        bit          c;
        bit          l;
        bit          e;
        bit          ud;
        logic [15:0] v;
        logic [7:0]  exp_cnt;
        bit          exp_cy;
        bit          exp_ov;
    } vec_t;

    localparam int NV = 15;
    vec_t vt[NV];

    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0}; // clr
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h00A5, 8'h95, 1'b0, 1'b0}; // clamp high digit
        vt[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h96, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0099, 8'h99, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1}; // wrap up
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1}; // carry drops
        vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h99, 1'b1, 1'b1}; // borrow
        vt[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0055, 8'h00, 1'b0, 1'b0}; // clr beats load
        vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0009, 8'h09, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 8'h10, 1'b0, 1'b0}; // ripple
        vt[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h00FF, 8'h99, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h003C, 8'h39, 1'b0, 1'b0}; // load beats terminal up
        vt[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0042, 8'h42, 1'b0, 1'b0}; // load beats terminal down
        vt[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h41, 1'b0, 1'b0};

        model_reset();
        #2;
        chk_reset_state("por");
        #10;
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            cycle(vt[i].c, vt[i].l, vt[i].e, vt[i].ud, vt[i].v);
            chk($sformatf("vec%0d.count", i), 32'(cnt_a), 32'(vt[i].exp_cnt));
            chk($sformatf("vec%0d.carry", i), 32'(cy_a), 32'(vt[i].exp_cy));
            chk($sformatf("vec%0d.ovf", i), 32'(ov_a), 32'(vt[i].exp_ov));
        end

        // 100 up steps from 00: ripple at 09->10, wrap at the 100th
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
            if (i == 9)  chk("up.ripple10", 32'(cnt_a), 32'h10);
            if (i == 98) chk("up.at99", 32'({cnt_a, cy_a, ov_a}), 32'({8'h99, 1'b0, 1'b0}));
            if (i == 99) chk("up.wrap", 32'({cnt_a, cy_a, ov_a}), 32'({8'h00, 1'b1, 1'b1}));
        end

        // Down from 00: wrap vs saturate
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        chk("down.wrap", 32'({cnt_a, cy_a}), 32'({8'h99, 1'b1}));
        chk("down.sat", 32'({cnt_b, cy_b, ov_b}), 32'({8'h00, 1'b0, 1'b1}));

        // Async reset mid-count at 47, then first step after release
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0047);
        chk("pre_rst.count", 32'(cnt_a), 32'h47);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_reset_state("async_rst");
        #3;
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
        chk("post_rst.step", 32'(cnt_a), 32'h01);

        // TICK_DIV=3: en 1,1,0,1 gives one step on the 4th edge
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        chk("div3.frozen", 32'(cnt_c), 32'h00);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
        chk("div3.step", 32'(cnt_c), 32'h01);
        // Direction flip mid-prescale keeps phase: step on the third enabled edge
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        chk("div3.phase_hold", 32'(cnt_c), 32'h01);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        chk("div3.phase_step", 32'(cnt_c), 32'h00);

        // 4 digits: 9999 up -> 0000 with carry; clr drops ovf
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 16'h0);
        chk("d4.wrap", 32'({cnt_d, cy_d, z_d, ov_d}), 32'({16'h0000, 1'b1, 1'b1, 1'b1}));
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        chk("d4.clr_ovf", 32'({ov_d, cy_d}), 32'h0);

        // Short random run checked only by the scoreboard
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
